// File: rtl/pll_mgr_pkg.sv
// rtl/pll_mgr_pkg.sv - shared state encoding for the PLL lock manager
package pll_mgr_pkg;

   typedef enum logic [2:0] {
      RESET       = 3'd0,
      WAIT_LOCK   = 3'd1,
      STABLE_WAIT = 3'd2,
      LOCKED      = 3'd3,
      FAIL        = 3'd4
   } pll_state_e;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchroniser, asynchronous reset to 0
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_mgr.sv
// rtl/pll_lock_mgr.sv - PLL reset sequencer and lock supervisor with retry/timeout
// Lock-loss statistics counter is built only when PLL_LOCK_STATS_EN is defined.
module pll_lock_mgr
   import pll_mgr_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 27000,
   parameter int LOCK_STABLE  = 256,
   parameter int MAX_RETRY    = 3,
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_W        = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pll_locked,
   input  logic                           restart,
   output logic                           pll_rst,
   output logic                           locked,
   output logic                           fail,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
   output logic [CNT_W-1:0]               loss_cnt
);

   localparam int RC_W = $clog2(RST_CYCLES + 1);
   localparam int TO_W = $clog2(LOCK_TIMEOUT);
   localparam int ST_W = $clog2(LOCK_STABLE + 1);
   localparam int RT_W = $clog2(MAX_RETRY + 1);

   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE - 1);
   localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

   pll_state_e      state_q, state_d;
   logic [RC_W-1:0] rc_q, rc_d;
   logic [TO_W-1:0] to_q, to_d, to_inc;
   logic [ST_W-1:0] st_q, st_d;
   logic [RT_W-1:0] retry_q, retry_d, retry_inc;
   logic            pll_rst_q, pll_rst_d;
   logic            locked_q, locked_d;
   logic            fail_q, fail_d;
   logic            expired;
   logic            lk_s;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk_s)
   );

   always_comb begin
      state_d   = state_q;
      rc_d      = rc_q;
      to_d      = to_q;
      st_d      = st_q;
      retry_d   = retry_q;
      // Timeout counter saturates so a late entry into STABLE_WAIT still sees expiry.
      expired   = (to_q == TO_LAST);
      to_inc    = expired ? to_q : to_q + 1'b1;
      retry_inc = retry_q + 1'b1;

      case (state_q)
         RESET: begin
            if (rc_q == RC_LAST) begin
               state_d = WAIT_LOCK;
               to_d    = '0;
            end else begin
               rc_d = rc_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            to_d = to_inc;
            if (lk_s) begin
               state_d = STABLE_WAIT;
               st_d    = '0;
            end else if (expired) begin
               retry_d = retry_inc;
               rc_d    = '0;
               state_d = (retry_inc == RT_MAX) ? FAIL : RESET;
            end
         end
         STABLE_WAIT: begin
            to_d = to_inc;
            st_d = st_q + 1'b1;
            if (!lk_s) begin
               state_d = WAIT_LOCK;
            end else if (st_q == ST_LAST) begin
               state_d = LOCKED;
               retry_d = '0;
            end else if (expired) begin
               retry_d = retry_inc;
               rc_d    = '0;
               state_d = (retry_inc == RT_MAX) ? FAIL : RESET;
            end
         end
         LOCKED: begin
            if (!lk_s) begin
               state_d = RESET;
               rc_d    = '0;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = RESET;
            rc_d    = '0;
         end
      endcase

      if (restart) begin
         state_d = RESET;
         rc_d    = '0;
         retry_d = '0;
      end

      pll_rst_d = (state_d == RESET) || (state_d == FAIL);
      locked_d  = (state_d == LOCKED);
      fail_d    = (state_d == FAIL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RESET;
         rc_q      <= '0;
         to_q      <= '0;
         st_q      <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         locked_q  <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rc_q      <= rc_d;
         to_q      <= to_d;
         st_q      <= st_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         locked_q  <= locked_d;
         fail_q    <= fail_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign locked    = locked_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

`ifdef PLL_LOCK_STATS_EN
   logic [CNT_W-1:0] loss_q, loss_d;

   // Counted independently of restart so a simultaneous loss is never dropped.
   always_comb begin
      loss_d = loss_q;
      if ((state_q == LOCKED) && !lk_s && (loss_q != '1)) begin
         loss_d = loss_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign loss_cnt = loss_q;
`else
   assign loss_cnt = '0;
`endif

endmodule
